systolic_array_input_skew: RTL and testbench
============================================

Name: systolic_array_input_skew

Overview:
- Upstream feeder for the systolic array MAC grid. Accepts one activation vector (N elements) per MAC step over a valid/ready handshake.
- Applies diagonal skew: row r receives element r, delayed by r steps.
- Generates the per-step MAC control (start, count, MAC_shift) that drives every MAC in_value/start/count/MAC_shift port.
- Drains with zero bubbles after the last vector, then signals done.

Parameters:
DATA_W, 16, element width (FP16)
N, 4, array rows / vector elements
MUL_LEN, 2, multiply cycles per MAC step
ADD_LEN, 3, add cycles per MAC step

Ports:
CLK  input  1  clock
nRST  input  1  asynchronous active-low reset
in_valid  input  1  in_vec valid
in_ready  output  1  block can take in_vec this cycle
in_vec  input  N*DATA_W  activation vector; element r at [r*DATA_W +: DATA_W]
row_value  output  N*DATA_W  skewed value per row, to MAC in_value
row_valid  output  N  row r carries real data this step
start  output  1  MAC start, one cycle at first cycle of each step
count  output  $clog2(MUL_LEN+ADD_LEN)  cycle index within step, to MAC count
MAC_shift  output  1  last cycle of step; MACs pass data on
busy  output  1  state != IDLE
done  output  1  one-cycle pulse when pipeline fully drained

Behaviour:
- Clock and reset: one clock CLK; reset nRST is asynchronous, active-low.
- Step period: P = MUL_LEN+ADD_LEN.
- Registers:
  - state {IDLE, RUN, DRAIN}.
  - step counter cnt, 0..P-1, wraps P-1 -> 0.
  - Row r has an r-deep delay line of {valid, DATA_W} entries. Row 0 is the captured vector itself.
- Reset (any time, including mid-step):
  - state=IDLE, cnt=0, all delay lines and the capture register cleared.
  - row_value=0, row_valid=0, start=0, MAC_shift=0, count=0, busy=0, done=0.
  - in_ready=1 once nRST deasserts.
  - A partially processed vector is discarded.
- in_ready: 1 in IDLE; 1 in RUN/DRAIN only when cnt==P-1; 0 otherwise. Accept = in_valid & in_ready.
- IDLE: on accept, capture in_vec and set the row0 valid bit. Next cycle: state=RUN, cnt=0.
- RUN/DRAIN:
  - cnt increments every cycle.
  - start = (cnt==0). MAC_shift = (cnt==P-1). count = cnt.
  - Outputs are held stable for the whole step.
- Step boundary (cycle with cnt==P-1), evaluated on that clock edge:
  - Every delay line shifts one position. Row 0 capture goes into the row1 line, etc.
  - If accept: capture new in_vec (valid=1), state=RUN.
  - Else: capture zeros (valid=0). Then:
    - if any valid bit remains anywhere after the shift, state=DRAIN;
    - otherwise state=IDLE and done=1 for the next cycle.
- New input during DRAIN (accept at cnt==P-1) returns to RUN with no lost step. Back-to-back vectors give one vector per P cycles with no gaps.
- Output mapping: row_value[r] / row_valid[r] = element r of the vector accepted r steps ago; 0/0 if none.
- N=1: no delay lines. IDLE is re-entered at the end of the first step without an accept.
- busy=1 in RUN and DRAIN. done never coincides with busy.
- Data path is pure movement; no arithmetic on elements.
- Latency: accept to row r first valid = 1 + r*P cycles.

Test Plan:
- Single vector {A,B,C,D} (N=4, P=5), accepted cycle 0 -> expected outputs:
  - start at cycles 1, 6, 11, 16; MAC_shift at cycles 5, 10, 15, 20; count runs 0..4 in each step.
  - row0=A at cycles 1-5, row1=B at 6-10, row2=C at 11-15, row3=D at 16-20, all other rows 0/invalid.
  - done=1 at cycle 21; busy drops at cycle 21.
- Back-to-back vectors V0..V3 held valid -> expected outputs:
  - in_ready high only at cycles 0, 5, 10, 15.
  - In step 4 (cycles 16-20), row_valid=1111 with row r = V(3-r)[r].
  - Drain completes with done at cycle 36.
- Vector accepted, in_valid drops, new vector presented during DRAIN -> expected outputs: accepted at the next cnt==4 cycle, state returns to RUN, the skew of the earlier vector continues uninterrupted, and no done pulse until the final drain.
- in_valid held high mid-step (cnt=2) -> in_ready=0 and no capture until cnt==4.
- nRST asserted at cnt=3 of step 2 -> all outputs 0 immediately (async), in_ready=1 after release, next vector behaves as in the single-vector case.
- N=1, P=5, one vector -> row0 valid for cycles 1-5, done at cycle 6.

Source files
------------

// File: rtl/systolic_array_input_skew_if.sv
// Handshake and MAC-facing bundle of the systolic array input skew feeder.
// The feeder itself uses the slave modport; the vector source sits on master.
interface systolic_array_input_skew_if #(
  parameter int DATA_W  = 16,
  parameter int N       = 4,
  parameter int MUL_LEN = 2,
  parameter int ADD_LEN = 3
);
  localparam int P     = MUL_LEN + ADD_LEN;
  localparam int CNT_W = (P > 1) ? $clog2(P) : 1;

  logic                in_valid;
  logic                in_ready;
  logic [N*DATA_W-1:0] in_vec;
  logic [N*DATA_W-1:0] row_value;
  logic [N-1:0]        row_valid;
  logic                start;
  logic [CNT_W-1:0]    count;
  logic                MAC_shift;
  logic                busy;
  logic                done;

  modport master (
    output in_valid, in_vec,
    input  in_ready, row_value, row_valid, start, count, MAC_shift, busy, done
  );

  modport slave (
    input  in_valid, in_vec,
    output in_ready, row_value, row_valid, start, count, MAC_shift, busy, done
  );
endinterface

// File: rtl/systolic_array_input_skew.sv
// Feeds one activation vector per MAC step into the grid, skewing row r by r
// steps, and generates the start/count/MAC_shift control shared by every MAC.
module systolic_array_input_skew #(
  parameter int DATA_W  = 16,
  parameter int N       = 4,
  parameter int MUL_LEN = 2,
  parameter int ADD_LEN = 3
) (
  input logic CLK,
  input logic nRST,
  systolic_array_input_skew_if.slave bus
);
  localparam int P     = MUL_LEN + ADD_LEN;
  localparam int CNT_W = (P > 1) ? $clog2(P) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(P - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [N*DATA_W-1:0] capVec_q;
  logic                capValid_q;
  logic                done_q;

  logic         busy;
  logic         boundary;
  logic         accept;
  logic         remain;
  logic [N-1:0] lineRemain;

  assign busy         = (state_q != IDLE);
  assign boundary     = busy && (cnt_q == LAST);
  assign bus.in_ready = (state_q == IDLE) || (cnt_q == LAST);
  assign accept       = bus.in_valid && bus.in_ready;

  // Anything still in flight after this boundary's shift: the capture moving
  // into row 1, or any delay-line entry that is not about to fall off the end.
  assign remain = (N > 1) ? (capValid_q | (|lineRemain)) : 1'b0;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      capVec_q   <= '0;
      capValid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (accept) begin
            capVec_q   <= bus.in_vec;
            capValid_q <= 1'b1;
            state_q    <= RUN;
          end
        end
        default: begin
          cnt_q <= boundary ? '0 : cnt_q + CNT_W'(1);
          if (boundary) begin
            if (accept) begin
              capVec_q   <= bus.in_vec;
              capValid_q <= 1'b1;
              state_q    <= RUN;
            end else begin
              capVec_q   <= '0;
              capValid_q <= 1'b0;
              if (remain) begin
                state_q <= DRAIN;
              end else begin
                state_q <= IDLE;
                done_q  <= 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

  assign bus.row_value[DATA_W-1:0] = capVec_q[DATA_W-1:0];
  assign bus.row_valid[0]          = capValid_q;
  assign lineRemain[0]             = 1'b0;

  // Row r holds element r of the last r vectors; its oldest entry drives the MAC row.
  for (genvar r = 1; r < N; r++) begin : g_row
    logic [DATA_W-1:0] lineData_q  [r];
    logic              lineValid_q [r];
    logic              remainHere;

    always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
        for (int k = 0; k < r; k++) begin
          lineData_q[k]  <= '0;
          lineValid_q[k] <= 1'b0;
        end
      end else if (boundary) begin
        lineData_q[0]  <= capVec_q[r*DATA_W +: DATA_W];
        lineValid_q[0] <= capValid_q;
        for (int k = 1; k < r; k++) begin
          lineData_q[k]  <= lineData_q[k-1];
          lineValid_q[k] <= lineValid_q[k-1];
        end
      end
    end

    always_comb begin
      remainHere = 1'b0;
      for (int k = 0; k < r - 1; k++) begin
        remainHere = remainHere | lineValid_q[k];
      end
    end

    assign lineRemain[r]                        = remainHere;
    assign bus.row_value[r*DATA_W +: DATA_W]    = lineData_q[r-1];
    assign bus.row_valid[r]                     = lineValid_q[r-1];
  end

  assign bus.busy      = busy;
  assign bus.start     = busy && (cnt_q == '0);
  assign bus.MAC_shift = boundary;
  assign bus.count     = cnt_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_systolic_array_input_skew.sv
// Bench for systolic_array_input_skew: directed vectors with literal expectations
// plus a per-cycle comparison against an arithmetic model of accepted vectors.
`timescale 1ns/1ps
module tb_systolic_array_input_skew;
  localparam int DW  = 16;
  localparam int N   = 4;
  localparam int MUL = 2;
  localparam int ADD = 3;
  localparam int P   = MUL + ADD;
  localparam int VW  = N * DW;

  logic clk  = 1'b0;
  logic nRST = 1'b1;
  int   tests    = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   checkOn  = 1'b0;

  always #5 clk = ~clk;

  systolic_array_input_skew_if #(.DATA_W(DW), .N(N), .MUL_LEN(MUL), .ADD_LEN(ADD)) bus ();
  systolic_array_input_skew_if #(.DATA_W(DW), .N(1), .MUL_LEN(MUL), .ADD_LEN(ADD)) bus1 ();

  systolic_array_input_skew #(.DATA_W(DW), .N(N), .MUL_LEN(MUL), .ADD_LEN(ADD)) dut (
    .CLK(clk), .nRST(nRST), .bus(bus)
  );

  systolic_array_input_skew #(.DATA_W(DW), .N(1), .MUL_LEN(MUL), .ADD_LEN(ADD)) dut1 (
    .CLK(clk), .nRST(nRST), .bus(bus1)
  );

  typedef struct {
    int            a;
    logic [VW-1:0] v;
  } acc_t;

  typedef struct packed {
    logic          busy;
    logic [VW-1:0] val;
    logic [N-1:0]  vld;
    logic [2:0]    cnt;
    logic          done;
    logic          ready;
  } exp_t;

  acc_t hist[$];

  // A vector accepted in cycle a occupies row r during cycles a+1+r*P .. a+(r+1)*P.
  function automatic exp_t modelAt(input int t);
    exp_t e;
    int   last;
    int   cntE;
    e    = '0;
    last = -1;
    cntE = 0;
    foreach (hist[i]) begin
      int a;
      a = hist[i].a;
      if (a > last) last = a;
      if (t >= a + 1 && t <= a + N * P) begin
        int r;
        r = (t - a - 1) / P;
        cntE = (t - a - 1) % P;
        e.busy = 1'b1;
        e.val[r*DW +: DW] = hist[i].v[r*DW +: DW];
        e.vld[r] = 1'b1;
      end
    end
    e.cnt   = 3'(cntE);
    e.done  = !e.busy && last >= 0 && t == last + N * P + 1;
    e.ready = !e.busy || cntE == P - 1;
    return e;
  endfunction

  function automatic logic modelReady(input int t);
    exp_t e;
    e = modelAt(t);
    return e.ready;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [VW-1:0] vec);
    bus.in_valid = valid;
    bus.in_vec   = vec;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [VW-1:0] mkVec(input int k);
    logic [VW-1:0] v;
    for (int r = 0; r < N; r++) v[r*DW +: DW] = 16'(16'h1000 * (k + 1) + 16'h0010 * r);
    return v;
  endfunction

  always @(negedge nRST) hist.delete();

  always @(posedge clk) begin
    if (nRST && bus.in_valid && modelReady(cyc)) hist.push_back('{a: cyc, v: bus.in_vec});
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    exp_t e;
    if (checkOn) begin
      e = modelAt(cyc);
      checkOutput("m_in_ready",  64'(bus.in_ready),  64'(e.ready));
      checkOutput("m_busy",      64'(bus.busy),      64'(e.busy));
      checkOutput("m_done",      64'(bus.done),      64'(e.done));
      checkOutput("m_count",     64'(bus.count),     64'(e.cnt));
      checkOutput("m_start",     64'(bus.start),     64'(e.busy && e.cnt == 3'd0));
      checkOutput("m_MAC_shift", 64'(bus.MAC_shift), 64'(e.busy && e.cnt == 3'(P - 1)));
      checkOutput("m_row_valid", 64'(bus.row_valid), 64'(e.vld));
      checkOutput("m_row_value", 64'(bus.row_value), 64'(e.val));
    end
  end

  initial begin
    applyStimulus(1'b0, '0);
    bus1.in_valid = 1'b0;
    bus1.in_vec   = '0;
    #1 nRST = 1'b0;
    #1;
    checkOutput("rst_busy",      64'(bus.busy),      64'd0);
    checkOutput("rst_row_valid", 64'(bus.row_valid), 64'd0);
    checkOutput("rst_done",      64'(bus.done),      64'd0);
    checkOutput("rst_start",     64'(bus.start),     64'd0);
    repeat (3) @(posedge clk);
    #1 nRST = 1'b1;
    checkOn = 1'b1;
    checkOutput("rst_in_ready",  64'(bus.in_ready),  64'd1);
    waitCycles(2);

    // Single vector {A,B,C,D}
    applyStimulus(1'b1, 64'hDDDD_CCCC_BBBB_AAAA);
    waitCycles(1);
    applyStimulus(1'b0, '0);
    checkOutput("sv_c1_start",  64'(bus.start),     64'd1);
    checkOutput("sv_c1_count",  64'(bus.count),     64'd0);
    checkOutput("sv_c1_valid",  64'(bus.row_valid), 64'b0001);
    checkOutput("sv_c1_value",  64'(bus.row_value), 64'h0000_0000_0000_AAAA);
    waitCycles(4);
    checkOutput("sv_c5_shift",  64'(bus.MAC_shift), 64'd1);
    checkOutput("sv_c5_count",  64'(bus.count),     64'd4);
    waitCycles(1);
    checkOutput("sv_c6_valid",  64'(bus.row_valid), 64'b0010);
    checkOutput("sv_c6_value",  64'(bus.row_value), 64'h0000_0000_BBBB_0000);
    waitCycles(10);
    checkOutput("sv_c16_valid", 64'(bus.row_valid), 64'b1000);
    checkOutput("sv_c16_value", 64'(bus.row_value), 64'hDDDD_0000_0000_0000);
    waitCycles(4);
    checkOutput("sv_c20_done",  64'(bus.done),      64'd0);
    waitCycles(1);
    checkOutput("sv_c21_done",  64'(bus.done),      64'd1);
    checkOutput("sv_c21_busy",  64'(bus.busy),      64'd0);
    waitCycles(1);
    checkOutput("sv_c22_done",  64'(bus.done),      64'd0);

    // Back-to-back V0..V3
    applyStimulus(1'b1, mkVec(0));
    checkOutput("bb_c0_ready",  64'(bus.in_ready),  64'd1);
    waitCycles(1);
    applyStimulus(1'b1, mkVec(1));
    waitCycles(2);
    checkOutput("bb_c3_ready",  64'(bus.in_ready),  64'd0);
    waitCycles(2);
    checkOutput("bb_c5_ready",  64'(bus.in_ready),  64'd1);
    waitCycles(1);
    applyStimulus(1'b1, mkVec(2));
    waitCycles(4);
    checkOutput("bb_c10_ready", 64'(bus.in_ready),  64'd1);
    waitCycles(1);
    applyStimulus(1'b1, mkVec(3));
    waitCycles(4);
    checkOutput("bb_c15_ready", 64'(bus.in_ready),  64'd1);
    waitCycles(1);
    applyStimulus(1'b0, '0);
    checkOutput("bb_c16_ready", 64'(bus.in_ready),  64'd0);
    waitCycles(2);
    checkOutput("bb_c18_valid", 64'(bus.row_valid), 64'b1111);
    checkOutput("bb_c18_value", 64'(bus.row_value), 64'h1030_2020_3010_4000);
    waitCycles(17);
    checkOutput("bb_c35_done",  64'(bus.done),      64'd0);
    waitCycles(1);
    checkOutput("bb_c36_done",  64'(bus.done),      64'd1);
    waitCycles(1);

    // Vector presented mid-step during DRAIN
    applyStimulus(1'b1, 64'h0004_0003_0002_0001);
    waitCycles(1);
    applyStimulus(1'b0, '0);
    waitCycles(7);
    applyStimulus(1'b1, 64'h0040_0030_0020_0010);
    checkOutput("dr_c8_ready",  64'(bus.in_ready),  64'd0);
    waitCycles(1);
    checkOutput("dr_c9_ready",  64'(bus.in_ready),  64'd0);
    waitCycles(1);
    checkOutput("dr_c10_ready", 64'(bus.in_ready),  64'd1);
    waitCycles(1);
    applyStimulus(1'b0, '0);
    checkOutput("dr_c11_valid", 64'(bus.row_valid), 64'b0101);
    checkOutput("dr_c11_value", 64'(bus.row_value), 64'h0000_0003_0000_0010);
    waitCycles(10);
    checkOutput("dr_c21_done",  64'(bus.done),      64'd0);
    checkOutput("dr_c21_value", 64'(bus.row_value), 64'h0000_0030_0000_0000);
    waitCycles(10);
    checkOutput("dr_c31_done",  64'(bus.done),      64'd1);
    waitCycles(1);

    // Asynchronous reset at cnt=3 of step 2
    applyStimulus(1'b1, 64'h4444_3333_2222_1111);
    waitCycles(1);
    applyStimulus(1'b0, '0);
    waitCycles(8);
    checkOutput("ar_pre_count", 64'(bus.count),     64'd3);
    checkOutput("ar_pre_valid", 64'(bus.row_valid), 64'b0010);
    nRST = 1'b0;
    #1;
    checkOutput("ar_busy",      64'(bus.busy),      64'd0);
    checkOutput("ar_valid",     64'(bus.row_valid), 64'd0);
    checkOutput("ar_value",     64'(bus.row_value), 64'd0);
    checkOutput("ar_count",     64'(bus.count),     64'd0);
    checkOutput("ar_start",     64'(bus.start),     64'd0);
    checkOutput("ar_shift",     64'(bus.MAC_shift), 64'd0);
    checkOutput("ar_done",      64'(bus.done),      64'd0);
    waitCycles(1);
    nRST = 1'b1;
    checkOutput("ar_rel_ready", 64'(bus.in_ready),  64'd1);
    applyStimulus(1'b1, 64'h8888_7777_6666_5555);
    waitCycles(1);
    applyStimulus(1'b0, '0);
    checkOutput("ar_c1_start",  64'(bus.start),     64'd1);
    checkOutput("ar_c1_value",  64'(bus.row_value), 64'h0000_0000_0000_5555);
    waitCycles(20);
    checkOutput("ar_c21_done",  64'(bus.done),      64'd1);
    waitCycles(1);

    // N=1 instance
    bus1.in_valid = 1'b1;
    bus1.in_vec   = 16'h5A5A;
    waitCycles(1);
    bus1.in_valid = 1'b0;
    bus1.in_vec   = '0;
    checkOutput("n1_c1_valid",  64'(bus1.row_valid), 64'd1);
    checkOutput("n1_c1_value",  64'(bus1.row_value), 64'h5A5A);
    checkOutput("n1_c1_start",  64'(bus1.start),     64'd1);
    waitCycles(4);
    checkOutput("n1_c5_shift",  64'(bus1.MAC_shift), 64'd1);
    checkOutput("n1_c5_valid",  64'(bus1.row_valid), 64'd1);
    waitCycles(1);
    checkOutput("n1_c6_done",   64'(bus1.done),      64'd1);
    checkOutput("n1_c6_busy",   64'(bus1.busy),      64'd0);
    checkOutput("n1_c6_valid",  64'(bus1.row_valid), 64'd0);
    waitCycles(1);
    checkOutput("n1_c7_done",   64'(bus1.done),      64'd0);
    waitCycles(2);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end
endmodule
